usb_rx_framer: RTL and testbench

Frame builder between the FT600 245-fifo controller's RX AXI-stream (16-bit, `tkeep`/`tlast`) and the controller's TX AXI-stream. It buffers one host packet, then emits it wrapped in a fixed frame:

- a header word;
- a byte-length word;
- the payload;
- a 16-bit additive checksum word, carrying `tlast`.

It turns the plain loopback into a framed echo that host software can validate.

---
 rtl/usb_rx_framer.sv | 172 +++++++++++++++++
 tb/tb_usb_rx_framer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_framer.sv
// Buffers one host packet from the RX stream and re-emits it as a framed echo:
// header word, byte-length word, payload, then a 16-bit additive checksum word.
module usb_rx_framer #(
    parameter int          EA     = 9,
    parameter logic [15:0] HEADER = 16'hA55A
) (
    input  logic        clk,
    input  logic        rst,
    output logic        s_tready,
    input  logic        s_tvalid,
    input  logic [15:0] s_tdata,
    input  logic [1:0]  s_tkeep,
    input  logic        s_tlast,
    input  logic        m_tready,
    output logic        m_tvalid,
    output logic [15:0] m_tdata,
    output logic [1:0]  m_tkeep,
    output logic        m_tlast,
    output logic [7:0]  trunc_cnt
);

    localparam int DEPTH = 1 << EA;

    typedef enum logic [2:0] {
        COLLECT,
        HDR,
        LEN,
        PAY,
        CSUM
    } state_t;

    state_t state, state_nxt;

    logic          active;
    logic [EA:0]   wr_ptr;
    logic [EA:0]   rd_ptr;
    logic [EA-1:0] rd_addr;
    logic [14:0]   byte_cnt;
    logic [15:0]   csum;
    logic          trunc;

    logic [17:0]   mem [DEPTH];
    logic [17:0]   rd_q;

    logic          in_fire;
    logic          out_fire;
    logic          buf_full;
    logic          store;
    logic          last_word;
    logic [15:0]   masked;
    logic [1:0]    pop;

    assign in_fire   = s_tvalid && s_tready;
    assign out_fire  = m_tvalid && m_tready;
    assign buf_full  = wr_ptr[EA];
    assign store     = in_fire && (s_tkeep != 2'b00) && !buf_full;
    assign last_word = (rd_ptr == (wr_ptr - (EA+1)'(1)));
    assign masked    = {s_tkeep[1] ? s_tdata[15:8] : 8'h00,
                        s_tkeep[0] ? s_tdata[7:0]  : 8'h00};
    assign pop       = {1'b0, s_tkeep[1]} + {1'b0, s_tkeep[0]};

    // Holds s_tready low until the first clock edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (in_fire && s_tlast) state_nxt = HDR;
            HDR:     if (out_fire) state_nxt = LEN;
            LEN:     if (out_fire) state_nxt = (wr_ptr == '0) ? CSUM : PAY;
            PAY:     if (out_fire && last_word) state_nxt = CSUM;
            CSUM:    if (out_fire) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        s_tready = 1'b0;
        m_tvalid = 1'b0;
        m_tdata  = 16'h0000;
        m_tkeep  = 2'b00;
        m_tlast  = 1'b0;
        case (state)
            COLLECT: s_tready = active;
            HDR: begin
                m_tvalid = 1'b1;
                m_tdata  = HEADER;
                m_tkeep  = 2'b11;
            end
            LEN: begin
                m_tvalid = 1'b1;
                m_tdata  = {trunc, byte_cnt};
                m_tkeep  = 2'b11;
            end
            PAY: begin
                m_tvalid = 1'b1;
                m_tdata  = rd_q[15:0];
                m_tkeep  = rd_q[17:16];
            end
            CSUM: begin
                m_tvalid = 1'b1;
                m_tdata  = csum;
                m_tkeep  = 2'b11;
                m_tlast  = 1'b1;
            end
            default: ;
        endcase
    end

    // Packet accumulators; cleared once the checksum beat has been handed off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            byte_cnt <= '0;
            csum     <= '0;
            trunc    <= 1'b0;
        end else if (state == CSUM && out_fire) begin
            wr_ptr   <= '0;
            byte_cnt <= '0;
            csum     <= '0;
            trunc    <= 1'b0;
        end else if (store) begin
            wr_ptr   <= wr_ptr + (EA+1)'(1);
            byte_cnt <= byte_cnt + 15'(pop);
            csum     <= csum + masked;
        end else if (in_fire && (s_tkeep != 2'b00) && buf_full) begin
            trunc    <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trunc_cnt <= '0;
        end else if (state == CSUM && out_fire && trunc && trunc_cnt != 8'hFF) begin
            trunc_cnt <= trunc_cnt + 8'd1;
        end
    end

    // rd_ptr is the word currently presented; rd_addr is the word presented next cycle,
    // so the synchronous read always lands in time and a stall simply re-reads the same word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (state == PAY && out_fire) begin
            rd_ptr <= last_word ? '0 : rd_ptr + (EA+1)'(1);
        end
    end

    assign rd_addr = (state == PAY && out_fire) ? rd_ptr[EA-1:0] + EA'(1) : rd_ptr[EA-1:0];

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr[EA-1:0]] <= {s_tkeep, masked};
        end
        rd_q <= mem[rd_addr];
    end

endmodule

// File: tb/tb_usb_rx_framer.sv
// Scoreboard bench for usb_rx_framer (EA=4): directed packets push their expected
// frames into a queue, and a negedge monitor pops and compares every output handshake.
module tb_usb_rx_framer;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  keep;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        s_tready;
    logic        s_tvalid;
    logic [15:0] s_tdata;
    logic [1:0]  s_tkeep;
    logic        s_tlast;
    logic        m_tready;
    logic        m_tvalid;
    logic [15:0] m_tdata;
    logic [1:0]  m_tkeep;
    logic        m_tlast;
    logic [7:0]  trunc_cnt;

    int    checks = 0;
    int    errors = 0;
    beat_t sb[$];
    logic  stall_mode = 1'b0;
    logic  held_v = 1'b0;
    beat_t held;

    usb_rx_framer #(.EA(4), .HEADER(16'hA55A)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tready  (s_tready),
        .s_tvalid  (s_tvalid),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tlast   (s_tlast),
        .m_tready  (m_tready),
        .m_tvalid  (m_tvalid),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tlast   (m_tlast),
        .trunc_cnt (trunc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushBeat(input logic [15:0] d, input logic [1:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        sb.push_back(b);
    endtask

    // Drives one input beat (called just after a rising edge) and waits for its handshake.
    task automatic applyStimulus(input logic [15:0] d, input logic [1:0] k, input logic l);
        int   n;
        logic rdy;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        n = 0;
        do begin
            @(negedge clk);
            rdy = s_tready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 2000);
        if (!rdy) begin
            checks++;
            errors++;
            $display("[TB] FAIL input_handshake_timeout: got no s_tready, expected accept of %h", d);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic checkBurst(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("burst_valid", 32'(m_tvalid), 32'd1);
        end
        @(negedge clk);
        checkOutput("burst_end_valid", 32'(m_tvalid), 32'd0);
        checkOutput("ready_return", 32'(s_tready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_remaining", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compares each handshake against the queue head, and checks hold and ready rules.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                checkOutput("stall_hold", 32'({m_tvalid, m_tdata, m_tkeep, m_tlast}),
                            32'({1'b1, held.data, held.keep, held.last}));
            end
            if (m_tvalid) begin
                checkOutput("s_tready_during_emit", 32'(s_tready), 32'd0);
            end
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got %h, expected no output", m_tdata);
                end else begin
                    e = sb.pop_front();
                    checkOutput("m_tdata", 32'(m_tdata), 32'(e.data));
                    checkOutput("m_tkeep", 32'(m_tkeep), 32'(e.keep));
                    checkOutput("m_tlast", 32'(m_tlast), 32'(e.last));
                end
            end
            held_v    = m_tvalid && !m_tready;
            held.data = m_tdata;
            held.keep = m_tkeep;
            held.last = m_tlast;
        end
    end

    initial begin
        int n;
        rst      = 1'b1;
        m_tready = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_s_tready", 32'(s_tready), 32'd0);
        checkOutput("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("rst_m_tdata", 32'(m_tdata), 32'd0);
        checkOutput("rst_m_tkeep", 32'(m_tkeep), 32'd0);
        checkOutput("rst_m_tlast", 32'(m_tlast), 32'd0);
        checkOutput("rst_trunc_cnt", 32'(trunc_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_after_reset", 32'(s_tready), 32'd1);

        // Basic frame, also checks latency and n+3 output cycles.
        pushBeat(16'hA55A, 2'b11, 0); pushBeat(16'h0006, 2'b11, 0);
        pushBeat(16'h0001, 2'b11, 0); pushBeat(16'h0002, 2'b11, 0);
        pushBeat(16'h0003, 2'b11, 0); pushBeat(16'h0006, 2'b11, 1);
        applyStimulus(16'h0001, 2'b11, 0);
        applyStimulus(16'h0002, 2'b11, 0);
        applyStimulus(16'h0003, 2'b11, 1);
        checkBurst(6);
        waitDrain();
        checkOutput("trunc_cnt_basic", 32'(trunc_cnt), 32'd0);

        // Odd trailing byte.
        pushBeat(16'hA55A, 2'b11, 0); pushBeat(16'h0003, 2'b11, 0);
        pushBeat(16'h1234, 2'b11, 0); pushBeat(16'h00EF, 2'b01, 0);
        pushBeat(16'h1323, 2'b11, 1);
        applyStimulus(16'h1234, 2'b11, 0);
        applyStimulus(16'hBEEF, 2'b01, 1);
        waitDrain();

        // Upper-byte-only beat plus an empty-keep beat in the middle.
        pushBeat(16'hA55A, 2'b11, 0); pushBeat(16'h0003, 2'b11, 0);
        pushBeat(16'hAB00, 2'b10, 0); pushBeat(16'h0102, 2'b11, 0);
        pushBeat(16'hAC02, 2'b11, 1);
        applyStimulus(16'hAB12, 2'b10, 0);
        applyStimulus(16'h7777, 2'b00, 0);
        applyStimulus(16'h0102, 2'b11, 1);
        waitDrain();

        // Overflow: 20 words into a 16-word buffer.
        pushBeat(16'hA55A, 2'b11, 0); pushBeat(16'h8020, 2'b11, 0);
        for (int i = 0; i < 16; i++) pushBeat(16'hFFFF, 2'b11, 0);
        pushBeat(16'hFFF0, 2'b11, 1);
        for (int i = 1; i <= 20; i++) applyStimulus(16'hFFFF, 2'b11, (i == 20));
        waitDrain();
        checkOutput("trunc_cnt_overflow", 32'(trunc_cnt), 32'd1);

        pushBeat(16'hA55A, 2'b11, 0); pushBeat(16'h0002, 2'b11, 0);
        pushBeat(16'h5555, 2'b11, 0); pushBeat(16'h5555, 2'b11, 1);
        applyStimulus(16'h5555, 2'b11, 1);
        waitDrain();

        // Exact fill: tlast lands in the final slot, not truncated.
        pushBeat(16'hA55A, 2'b11, 0); pushBeat(16'h0020, 2'b11, 0);
        for (int i = 1; i <= 16; i++) pushBeat(16'(i), 2'b11, 0);
        pushBeat(16'h0088, 2'b11, 1);
        for (int i = 1; i <= 16; i++) applyStimulus(16'(i), 2'b11, (i == 16));
        waitDrain();
        checkOutput("trunc_cnt_exact_fill", 32'(trunc_cnt), 32'd1);

        // Empty packet.
        pushBeat(16'hA55A, 2'b11, 0); pushBeat(16'h0000, 2'b11, 0);
        pushBeat(16'h0000, 2'b11, 1);
        applyStimulus(16'h5A5A, 2'b00, 1);
        checkBurst(3);
        waitDrain();

        // Backpressure with a back-to-back second packet.
        stall_mode = 1'b1;
        pushBeat(16'hA55A, 2'b11, 0); pushBeat(16'h0010, 2'b11, 0);
        for (int i = 0; i < 8; i++) pushBeat(16'h0100 + 16'(i), 2'b11, 0);
        pushBeat(16'h081C, 2'b11, 1);
        pushBeat(16'hA55A, 2'b11, 0); pushBeat(16'h0002, 2'b11, 0);
        pushBeat(16'h00C3, 2'b11, 0); pushBeat(16'h00C3, 2'b11, 1);
        for (int i = 0; i < 8; i++) applyStimulus(16'h0100 + 16'(i), 2'b11, (i == 7));
        applyStimulus(16'h00C3, 2'b11, 1);
        waitDrain();
        stall_mode = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-PAY: queue holds the full frame, reset is applied after the first payload word.
        pushBeat(16'hA55A, 2'b11, 0); pushBeat(16'h0008, 2'b11, 0);
        for (int i = 0; i < 4; i++) pushBeat(16'h0011 + 16'(i), 2'b11, 0);
        pushBeat(16'h004A, 2'b11, 1);
        for (int i = 0; i < 4; i++) applyStimulus(16'h0011 + 16'(i), 2'b11, (i == 3));
        n = 0;
        while (sb.size() > 4 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("reached_pay", 32'(sb.size()), 32'd4);
        rst = 1'b1;
        #1;
        checkOutput("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("midrst_m_tdata", 32'(m_tdata), 32'd0);
        checkOutput("midrst_m_tkeep", 32'(m_tkeep), 32'd0);
        checkOutput("midrst_m_tlast", 32'(m_tlast), 32'd0);
        checkOutput("midrst_s_tready", 32'(s_tready), 32'd0);
        checkOutput("midrst_trunc_cnt", 32'(trunc_cnt), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_after_midrst", 32'(s_tready), 32'd1);
        pushBeat(16'hA55A, 2'b11, 0); pushBeat(16'h0002, 2'b11, 0);
        pushBeat(16'h00AA, 2'b11, 0); pushBeat(16'h00AA, 2'b11, 1);
        applyStimulus(16'h00AA, 2'b11, 1);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
